// File: rtl/sig_gen_pkg.sv
// Shared constants and types for the sine-generation blocks.
// Phases carry 29 fractional bits of radians.
package sig_gen_pkg;

   localparam int PHASE_W  = 31;
   localparam int DELTA_W  = 30;
   localparam int SAMPLE_W = 16;

   localparam logic [31:0] PI      = 32'h6487ED51;
   localparam logic [31:0] HALF_PI = PI >> 1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SCAN   = 3'd1,
      ST_ISSUE  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_STORE  = 3'd4,
      ST_COMMIT = 3'd5
   } sched_state_t;

endpackage

// File: rtl/phase_fold.sv
// Phase advance with a single pi fold, keeping the phase in the CORDIC input range.
// When a fold happens, toggle_o tells the caller to flip the output sign.
module phase_fold
   import sig_gen_pkg::*;
(
   input  logic [PHASE_W-1:0] phase_i,
   input  logic [DELTA_W-1:0] delta_i,
   output logic [PHASE_W-1:0] phase_o,
   output logic               toggle_o
);

   logic [PHASE_W:0] sum_s;

   // Advance the phase; fold by pi when the sum leaves [-pi/2, pi/2]
   always_comb begin
      sum_s = {phase_i[PHASE_W-1], phase_i} + {2'b00, delta_i};
      if (!sum_s[PHASE_W] && (sum_s > HALF_PI)) begin
         phase_o  = sum_s[PHASE_W-1:0] - PI[PHASE_W-1:0];
         toggle_o = 1'b1;
      end else begin
         phase_o  = sum_s[PHASE_W-1:0];
         toggle_o = 1'b0;
      end
   end

endmodule

// File: rtl/sin_voice_scheduler.sv
// Shares one CORDIC sine core across NUM_VOICES oscillators.
// Each sample tick produces one coherent frame of voice samples.
module sin_voice_scheduler
   import sig_gen_pkg::*;
#(
   parameter int NUM_VOICES     = 4,
   parameter int CORDIC_TIMEOUT = 63
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           sample_tick,
   input  logic [NUM_VOICES-1:0]          voice_enable,
   input  logic [NUM_VOICES*DELTA_W-1:0]  delta_angle,
   output logic [23:0]                    cordic_angle,
   output logic                           cordic_start,
   input  logic                           cordic_busy,
   input  logic [SAMPLE_W-1:0]            cordic_out,
   input  logic                           cordic_out_valid,
   output logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
   output logic                           frame_valid,
   output logic                           tick_overrun
);

   localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int CNT_W = $clog2(NUM_VOICES + 1);
   localparam int TMO_W = $clog2(CORDIC_TIMEOUT + 1);

   sched_state_t                  state_q, state_d;
   logic [NUM_VOICES-1:0]         mask_q, mask_d;
   logic [IDX_W-1:0]              idx_q, idx_d;
   logic [CNT_W-1:0]              next_q, next_d;
   logic [TMO_W-1:0]              timer_q, timer_d;
   logic                          neg_cur_q, neg_cur_d;
   logic                          timed_out_q, timed_out_d;
   logic [SAMPLE_W-1:0]           result_q, result_d;
   logic [PHASE_W-1:0]            phase_q [NUM_VOICES];
   logic [PHASE_W-1:0]            phase_d [NUM_VOICES];
   logic                          neg_q [NUM_VOICES];
   logic                          neg_d [NUM_VOICES];
   logic [SAMPLE_W-1:0]           shadow_q [NUM_VOICES];
   logic [SAMPLE_W-1:0]           shadow_d [NUM_VOICES];
   logic                          cordic_start_q, cordic_start_d;
   logic [23:0]                   cordic_angle_q, cordic_angle_d;
   logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample_q, voice_sample_d;
   logic                          frame_valid_q, frame_valid_d;
   logic                          found_s;
   logic [PHASE_W-1:0]            fold_phase_s;
   logic                          fold_toggle_s;

   phase_fold u_fold (
      .phase_i  (phase_q[idx_q]),
      .delta_i  (delta_angle[int'(idx_q)*DELTA_W +: DELTA_W]),
      .phase_o  (fold_phase_s),
      .toggle_o (fold_toggle_s)
   );

   // Next-state and datapath updates for the scheduler FSM
   always_comb begin
      state_d        = state_q;
      mask_d         = mask_q;
      idx_d          = idx_q;
      next_d         = next_q;
      timer_d        = timer_q;
      neg_cur_d      = neg_cur_q;
      timed_out_d    = timed_out_q;
      result_d       = result_q;
      phase_d        = phase_q;
      neg_d          = neg_q;
      shadow_d       = shadow_q;
      cordic_start_d = 1'b0;
      cordic_angle_d = cordic_angle_q;
      voice_sample_d = voice_sample_q;
      frame_valid_d  = 1'b0;
      found_s        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (sample_tick) begin
               mask_d  = voice_enable;
               next_d  = '0;
               state_d = ST_SCAN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SCAN: begin
            for (int j = 0; j < NUM_VOICES; j++) begin
               if (!mask_q[j]) begin
                  phase_d[j]  = '0;
                  neg_d[j]    = 1'b0;
                  shadow_d[j] = '0;
               end else if (!found_s && (CNT_W'(j) >= next_q)) begin
                  found_s = 1'b1;
                  idx_d   = IDX_W'(j);
               end else begin
                  found_s = found_s;
               end
            end
            state_d = found_s ? ST_ISSUE : ST_COMMIT;
         end
         ST_ISSUE: begin
            if (!cordic_busy) begin
               cordic_start_d = 1'b1;
               cordic_angle_d = phase_q[idx_q][PHASE_W-1:7];
               neg_cur_d      = neg_q[idx_q];
               timer_d        = '0;
               state_d        = ST_WAIT;
            end else begin
               state_d = ST_ISSUE;
            end
         end
         ST_WAIT: begin
            if (cordic_out_valid) begin
               result_d    = cordic_out;
               timed_out_d = 1'b0;
               state_d     = ST_STORE;
            end else if (timer_q == TMO_W'(CORDIC_TIMEOUT - 1)) begin
               result_d    = '0;
               timed_out_d = 1'b1;
               state_d     = ST_STORE;
            end else begin
               timer_d = timer_q + TMO_W'(1);
            end
         end
         ST_STORE: begin
            // Two's-complement negate; -32768 wraps onto itself
            shadow_d[idx_q] = neg_cur_q ? (SAMPLE_W'(0) - result_q) : result_q;
            if (!timed_out_q) begin
               phase_d[idx_q] = fold_phase_s;
               neg_d[idx_q]   = neg_q[idx_q] ^ fold_toggle_s;
            end else begin
               phase_d[idx_q] = phase_q[idx_q];
            end
            next_d  = CNT_W'(idx_q) + CNT_W'(1);
            state_d = ST_SCAN;
         end
         ST_COMMIT: begin
            for (int j = 0; j < NUM_VOICES; j++) begin
               voice_sample_d[j*SAMPLE_W +: SAMPLE_W] = shadow_q[j];
            end
            frame_valid_d = 1'b1;
            state_d       = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         mask_q         <= '0;
         idx_q          <= '0;
         next_q         <= '0;
         timer_q        <= '0;
         neg_cur_q      <= 1'b0;
         timed_out_q    <= 1'b0;
         result_q       <= '0;
         cordic_start_q <= 1'b0;
         cordic_angle_q <= '0;
         voice_sample_q <= '0;
         frame_valid_q  <= 1'b0;
         for (int j = 0; j < NUM_VOICES; j++) begin
            phase_q[j]  <= '0;
            neg_q[j]    <= 1'b0;
            shadow_q[j] <= '0;
         end
      end else begin
         state_q        <= state_d;
         mask_q         <= mask_d;
         idx_q          <= idx_d;
         next_q         <= next_d;
         timer_q        <= timer_d;
         neg_cur_q      <= neg_cur_d;
         timed_out_q    <= timed_out_d;
         result_q       <= result_d;
         cordic_start_q <= cordic_start_d;
         cordic_angle_q <= cordic_angle_d;
         voice_sample_q <= voice_sample_d;
         frame_valid_q  <= frame_valid_d;
         phase_q        <= phase_d;
         neg_q          <= neg_d;
         shadow_q       <= shadow_d;
      end
   end

   assign cordic_start = cordic_start_q;
   assign cordic_angle = cordic_angle_q;
   assign voice_sample = voice_sample_q;
   assign frame_valid  = frame_valid_q;
   assign tick_overrun = sample_tick && (state_q != ST_IDLE);

endmodule

// File: tb/tb_sin_voice_scheduler.sv
// Bench for sin_voice_scheduler: a behavioural CORDIC stub plus a
// phase-accumulator reference model checked frame by frame.
module tb_sin_voice_scheduler;

   localparam int     NV    = 4;
   localparam longint PI_L  = 64'sh6487ED51;
   localparam longint HPI_L = 64'sh3243F6A8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              sample_tick = 1'b0;
   logic [NV-1:0]     voice_enable = '0;
   logic [NV*30-1:0]  delta_angle = '0;
   logic [23:0]       cordic_angle;
   logic              cordic_start;
   logic              cordic_busy = 1'b0;
   logic [15:0]       cordic_out = 16'd0;
   logic              cordic_out_valid = 1'b0;
   logic [NV*16-1:0]  voice_sample;
   logic              frame_valid;
   logic              tick_overrun;

   int n_tests = 0;
   int n_fail  = 0;
   int fv_cnt  = 0;
   int st_cnt  = 0;
   int ov_cnt  = 0;
   bit stub_mute = 1'b0;
   int stub_cnt = 0;
   logic [23:0] stub_ang = '0;

   longint      mph [NV];
   bit          mneg [NV];
   logic [15:0] mexp [NV];
   logic [29:0] dl [NV];

   sin_voice_scheduler #(.NUM_VOICES(NV), .CORDIC_TIMEOUT(63)) dut (
      .clk              (clk),
      .rst              (rst),
      .sample_tick      (sample_tick),
      .voice_enable     (voice_enable),
      .delta_angle      (delta_angle),
      .cordic_angle     (cordic_angle),
      .cordic_start     (cordic_start),
      .cordic_busy      (cordic_busy),
      .cordic_out       (cordic_out),
      .cordic_out_valid (cordic_out_valid),
      .voice_sample     (voice_sample),
      .frame_valid      (frame_valid),
      .tick_overrun     (tick_overrun)
   );

   always #5 clk = ~clk;

   // Ideal sine of a 24-bit angle with 22 fractional bits, rounded to Q1.15
   function automatic logic [15:0] sinq(input logic [23:0] ang);
      real a, s;
      int  r;
      a = $itor($signed(ang)) / 4194304.0;
      s = $sin(a) * 32767.0;
      if (s >= 0.0) r = $rtoi(s + 0.5);
      else          r = -$rtoi(0.5 - s);
      if (r > 32767)  r = 32767;
      if (r < -32768) r = -32768;
      return 16'(r);
   endfunction

   // CORDIC stub: 21-cycle latency, or never answers when muted
   always @(negedge clk) begin
      if (rst) begin
         cordic_busy      = 1'b0;
         cordic_out_valid = 1'b0;
         stub_cnt         = 0;
      end else begin
         cordic_out_valid = 1'b0;
         if (cordic_start && !stub_mute) begin
            cordic_busy = 1'b1;
            stub_ang    = cordic_angle;
            stub_cnt    = 21;
         end else if (stub_cnt > 0) begin
            stub_cnt = stub_cnt - 1;
            if (stub_cnt == 0) begin
               cordic_out       = sinq(stub_ang);
               cordic_out_valid = 1'b1;
               cordic_busy      = 1'b0;
            end
         end
      end
   end

   always @(posedge clk) begin
      if (frame_valid)  fv_cnt = fv_cnt + 1;
      if (cordic_start) st_cnt = st_cnt + 1;
      if (tick_overrun) ov_cnt = ov_cnt + 1;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_tol(input string tag, input int obs, input int exp);
      n_tests++;
      assert ((obs - exp <= 3) && (exp - obs <= 3)) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d(+-3)", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int v = 0; v < NV; v++) begin
         mph[v] = 0; mneg[v] = 1'b0; mexp[v] = 16'd0;
      end
   endtask

   // Reference: sample uses the phase before this frame's advance
   task automatic model_frame(input logic [NV-1:0] en, input bit mute);
      logic [15:0] s;
      for (int v = 0; v < NV; v++) begin
         if (!en[v]) begin
            mph[v] = 0; mneg[v] = 1'b0; mexp[v] = 16'd0;
         end else if (mute) begin
            mexp[v] = 16'd0;
         end else begin
            s = sinq(24'(mph[v] >>> 7));
            mexp[v] = mneg[v] ? 16'(16'd0 - s) : s;
            mph[v] = mph[v] + longint'(dl[v]);
            if (mph[v] > HPI_L) begin
               mph[v]  = mph[v] - PI_L;
               mneg[v] = !mneg[v];
            end
         end
      end
   endtask

   task automatic run_frame(input logic [NV-1:0] en, input bit mute, input bit ovr,
                            input bit use_gold, input int gold);
      int f0, s0, o0;
      bit got;
      voice_enable = en;
      for (int v = 0; v < NV; v++) delta_angle[v*30 +: 30] = dl[v];
      stub_mute = mute;
      f0 = fv_cnt; s0 = st_cnt; o0 = ov_cnt;
      @(negedge clk); sample_tick = 1'b1;
      @(negedge clk); sample_tick = 1'b0;
      if (ovr) begin
         repeat (9) @(negedge clk);
         sample_tick = 1'b1;
         @(negedge clk); sample_tick = 1'b0;
      end
      model_frame(en, mute);
      got = 1'b0;
      for (int c = 0; c < 900 && !got; c++) begin
         @(negedge clk);
         if (frame_valid) got = 1'b1;
      end
      chk("frame_seen", int'(got), 1);
      for (int v = 0; v < NV; v++)
         chk($sformatf("voice%0d", v), int'($signed(voice_sample[v*16 +: 16])),
             int'($signed(mexp[v])));
      if (use_gold)
         chk_tol("golden_v0", int'($signed(voice_sample[15:0])), gold);
      @(negedge clk);
      chk("frame_pulse_width", int'(frame_valid), 0);
      if (ovr) repeat (150) @(negedge clk);
      chk("frames_per_tick", fv_cnt - f0, 1);
      chk("starts_per_tick", st_cnt - s0, $countones(en));
      chk("overruns", ov_cnt - o0, ovr ? 1 : 0);
   endtask

   initial begin
      int gold [9];
      int f0;
      gold = '{0, 23170, 32767, 23170, 0, -23170, -32767, -23170, 0};
      model_reset();
      for (int v = 0; v < NV; v++) dl[v] = 30'd0;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_sample", int'(voice_sample != '0), 0);
      chk("rst_frame_valid", int'(frame_valid), 0);
      chk("rst_start", int'(cordic_start), 0);
      chk("rst_angle", int'(cordic_angle), 0);
      chk("rst_overrun", int'(tick_overrun), 0);

      // single voice at pi/4 per sample
      dl[0] = 30'h1921FB54;
      for (int k = 0; k < 9; k++) run_frame(4'b0001, 1'b0, 1'b0, 1'b1, gold[k]);

      // four voices: pi/4, pi/2, 0, pi/8
      dl[0] = 30'h1921FB54; dl[1] = 30'h3243F6A8; dl[2] = 30'd0; dl[3] = 30'h0C90FDAA;
      for (int k = 0; k < 5; k++) run_frame(4'b1111, 1'b0, 1'b0, 1'b0, 0);

      // voice 2 dropped, then re-enabled from zero phase
      dl[2] = 30'h2A000000;
      run_frame(4'b1111, 1'b0, 1'b0, 1'b0, 0);
      run_frame(4'b1011, 1'b0, 1'b0, 1'b0, 0);
      run_frame(4'b1011, 1'b0, 1'b0, 1'b0, 0);
      run_frame(4'b1111, 1'b0, 1'b0, 1'b0, 0);
      run_frame(4'b1111, 1'b0, 1'b0, 1'b0, 0);

      // overlapping tick is dropped
      run_frame(4'b1111, 1'b0, 1'b1, 1'b0, 0);

      // unresponsive core: every voice times out, phases hold
      run_frame(4'b1111, 1'b1, 1'b0, 1'b0, 0);
      run_frame(4'b1111, 1'b0, 1'b0, 1'b0, 0);

      // empty mask still commits an all-zero frame
      run_frame(4'b0000, 1'b0, 1'b0, 1'b0, 0);

      // randomized masks and increments
      for (int k = 0; k < 8; k++) begin
         for (int v = 0; v < NV; v++) dl[v] = 30'($urandom());
         run_frame(4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0, 0);
      end

      // reset while waiting on the core
      for (int v = 0; v < NV; v++) dl[v] = 30'h1921FB54;
      run_frame(4'b1111, 1'b0, 1'b0, 1'b0, 0);
      @(negedge clk); sample_tick = 1'b1;
      @(negedge clk); sample_tick = 1'b0;
      for (int c = 0; c < 50 && !cordic_start; c++) @(negedge clk);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_sample", int'(voice_sample != '0), 0);
      chk("midrst_frame_valid", int'(frame_valid), 0);
      chk("midrst_start", int'(cordic_start), 0);
      chk("midrst_angle", int'(cordic_angle), 0);
      rst = 1'b0;
      f0 = fv_cnt;
      repeat (200) @(negedge clk);
      chk("midrst_no_frame", fv_cnt - f0, 0);
      model_reset();
      run_frame(4'b1111, 1'b0, 1'b0, 1'b0, 0);
      run_frame(4'b1111, 1'b0, 1'b0, 1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
